// File: rtl/count_sequencer.sv
// Two-phase ownership sequencer for a shared up-counter, with a live
// req1 -> (count <= LIMIT) property monitor and sticky error flag.
module count_sequencer #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned THRESH = 2,
  parameter int unsigned LIMIT  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             req1,
  input  logic             req2,
  output logic             gnt1,
  output logic             gnt2,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PH1  = 2'd1,
    S_PH2  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] THRESH_W = WIDTH'(THRESH);
  localparam logic [WIDTH-1:0] LIMIT_W  = WIDTH'(LIMIT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_count_inc;
  logic             r_done;
  logic             r_err;
  logic             r_req1_q;
  logic             w_gnt1;
  logic             w_gnt2;
  logic             w_valid;

  // Grants are combinational and suppressed while reset is asserted.
  assign w_gnt1      = !rst && (r_state == S_PH1) && req1;
  assign w_gnt2      = !rst && (r_state == S_PH2) && req2;
  assign w_count_inc = r_count + WIDTH'(1);
  assign w_valid     = !r_req1_q || (r_count <= LIMIT_W);

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_req1_q <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_done   <= (w_state_nxt == S_DONE);
      r_err    <= r_err || !w_valid;
      r_req1_q <= req1;
    end
  end

  // Next-state and next-count logic; abort outranks phase hand-off.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    if (w_gnt1 || w_gnt2) begin
      w_count_nxt = w_count_inc;
    end
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_PH1;
          w_count_nxt = '0;
        end
      end
      S_PH1: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_gnt1 && (w_count_inc == THRESH_W)) begin
          w_state_nxt = S_PH2;
        end
      end
      S_PH2: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_gnt2 && (w_count_inc == LIMIT_W)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign gnt1  = w_gnt1;
  assign gnt2  = w_gnt2;
  assign count = r_count;
  assign busy  = (r_state == S_PH1) || (r_state == S_PH2);
  assign done  = r_done;
  assign valid = w_valid;
  assign err   = r_err;

endmodule
